// File: rtl/mul_share_arbiter.sv
// Round-robin front end that time-shares one start/done multiplier between NREQ requesters.
// Optional WAIT watchdog enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_share_arbiter #(
  parameter int NREQ    = 2,
  parameter int W       = 8,
  parameter int RW      = 16,
  parameter int TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [RW-1:0]     rsp_result,
  output logic              rsp_err,
  output logic              mul_start,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic              mul_done,
  input  logic [RW-1:0]     mul_result
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] owner_q, owner_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [RW-1:0]   res_q, res_d;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   win_idx;
  logic            win_found;
  logic [W-1:0]    sel_a, sel_b;

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // Two passes: indices at/above ptr first, then the wrapped ones below ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req_valid[i] && (i >= int'(ptr_q))) begin
        win_found = 1'b1;
        win_idx   = PW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req_valid[i] && (i < int'(ptr_q))) begin
        win_found = 1'b1;
        win_idx   = PW'(i);
      end
    end
  end

  always_comb begin
    grant = '0;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = win_found && (win_idx == PW'(i));
      if (grant[i]) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
`ifdef MUL_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          a_d     = sel_a;
          b_d     = sel_b;
          owner_d = grant;
          ptr_d   = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef MUL_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done) begin
          res_d   = mul_result;
`ifdef MUL_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = S_RESP;
        end
`ifdef MUL_ARB_TIMEOUT_EN
        // The TIMEOUT-th WAIT cycle without done aborts; done in that cycle still wins.
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign req_ready  = (state_q == S_IDLE) ? grant : '0;
  assign rsp_valid  = (state_q == S_RESP) ? owner_q : '0;
  assign mul_start  = (state_q == S_ISSUE);
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign rsp_result = res_q;
`ifdef MUL_ARB_TIMEOUT_EN
  assign rsp_err    = err_q;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a behavioural multiplier and a response scoreboard.
module tb_mul_share_arbiter;
  localparam int NREQ = 2;
  localparam int W    = 8;
  localparam int RW   = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready, rsp_valid;
  logic [RW-1:0]     rsp_result;
  logic              rsp_err, mul_start;
  logic [W-1:0]      mul_a, mul_b;
  logic              mul_done;
  logic [RW-1:0]     mul_result;

  mul_share_arbiter #(.NREQ(NREQ), .W(W), .RW(RW), .TIMEOUT(31)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done),
    .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREQ-1:0] owner;
    logic [RW-1:0]   res;
    logic            err;
  } exp_t;

  exp_t            exp_q[$];
  logic [2*W-1:0]  op_q[$];
  int              gl[$];
  int              n_pass = 0, n_chk = 0;
  int              cyc = 0, rsp_cnt = 0, start_cyc = 0, rsp_cyc = 0;
  int              mdly = 5, cnt = 0;
  bit              mute = 1'b0, act = 1'b0;
  logic            mdl_done = 1'b0, spur_done = 1'b0;
  logic [RW-1:0]   prod = '0;
  exp_t            e_new, e_pop;
  logic [W-1:0]    ta, tb;
  logic [2*W-1:0]  op;
  logic [NREQ-1:0] oh;

  assign mul_done   = mdl_done | spur_done;
  assign mul_result = mdl_done ? prod : 16'hA5A5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc++;

  // Multiplier model, acceptance scoreboard push, response pop; all sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      act      = 1'b0;
      mdl_done = 1'b0;
    end else begin
      mdl_done = 1'b0;
      if (act) begin
        cnt--;
        if (cnt == 0) begin
          mdl_done = 1'b1;
          act      = 1'b0;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          ta = req_a[i*W +: W];
          tb = req_b[i*W +: W];
          oh = '0;
          oh[i] = 1'b1;
          e_new.owner = oh;
          e_new.err   = mute;
          e_new.res   = mute ? '0 : ({{W{1'b0}}, ta} * {{W{1'b0}}, tb});
          exp_q.push_back(e_new);
          op_q.push_back({ta, tb});
          gl.push_back(i);
        end
      end
      if (mul_start) begin
        start_cyc = cyc;
        if (op_q.size() == 0) chk("start_unexpected", {31'd0, mul_start}, 32'd0);
        else begin
          op = op_q.pop_front();
          chk("mul_a_at_start", {24'd0, mul_a}, {24'd0, op[2*W-1:W]});
          chk("mul_b_at_start", {24'd0, mul_b}, {24'd0, op[W-1:0]});
        end
        prod = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
        act  = !mute;
        cnt  = mdly;
      end
      if (rsp_valid != '0) begin
        rsp_cnt++;
        rsp_cyc = cyc;
        if (exp_q.size() == 0) chk("rsp_unexpected", {30'd0, rsp_valid}, 32'd0);
        else begin
          e_pop = exp_q.pop_front();
          chk("rsp_owner", {30'd0, rsp_valid}, {30'd0, e_pop.owner});
          chk("rsp_result", {16'd0, rsp_result}, {16'd0, e_pop.res});
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e_pop.err});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int target, input int bound);
    for (int k = 0; k < bound && rsp_cnt < target; k++) tick();
    chk("rsp_arrive", rsp_cnt, target);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ready"}, {30'd0, req_ready}, 32'd0);
    chk({tag, "_rspv"},  {30'd0, rsp_valid}, 32'd0);
    chk({tag, "_start"}, {31'd0, mul_start}, 32'd0);
    chk({tag, "_a"},     {24'd0, mul_a}, 32'd0);
    chk({tag, "_b"},     {24'd0, mul_b}, 32'd0);
    chk({tag, "_res"},   {16'd0, rsp_result}, 32'd0);
    chk({tag, "_err"},   {31'd0, rsp_err}, 32'd0);
  endtask

  initial begin
    int c0, nr;
    logic [NREQ-1:0] o;

    repeat (2) tick();
    rst = 1'b0;
    chk_idle_zero("reset");

    // Single request, done 5 cycles after start
    mdly = 5;
    req_a = {8'd0, 8'd7};
    req_b = {8'd0, 8'd9};
    req_valid = 2'b01;
    #1;
    chk("t2_ready", {30'd0, req_ready}, 32'd1);
    c0 = cyc;
    tick();
    req_valid = '0;
    wait_rsp(1, 30);
    chk("t2_start_lat", start_cyc - c0, 1);
    chk("t2_rsp_lat", rsp_cyc - c0, 7);
    tick();
    chk("t2_hold", {16'd0, rsp_result}, 32'd63);

    // Spurious done while idle, then during ISSUE
    spur_done = 1'b1;
    tick();
    tick();
    spur_done = 1'b0;
    chk("t4_idle_start", {31'd0, mul_start}, 32'd0);
    chk("t4_idle_rsp", rsp_cnt, 1);
    mdly = 4;
    req_a = {8'd0, 8'd200};
    req_b = {8'd0, 8'd3};
    req_valid = 2'b01;
    spur_done = 1'b1;
    #1;
    chk("t4_ready", {30'd0, req_ready}, 32'd1);
    c0 = cyc;
    tick();
    req_valid = '0;
    chk("t4_issue", {31'd0, mul_start}, 32'd1);
    tick();
    spur_done = 1'b0;
    wait_rsp(2, 30);
    chk("t4_rsp_lat", rsp_cyc - c0, 6);

    // Multiplier never answers
    mute = 1'b1;
    req_a = {8'd0, 8'd5};
    req_b = {8'd0, 8'd5};
    req_valid = 2'b01;
    #1;
    chk("t5_ready", {30'd0, req_ready}, 32'd1);
    c0 = cyc;
    tick();
    req_valid = '0;
`ifdef MUL_ARB_TIMEOUT_EN
    wait_rsp(3, 60);
    chk("t5_start_lat", start_cyc - c0, 1);
    chk("t5_abort_lat", rsp_cyc - start_cyc, 32);
`else
    repeat (100) tick();
    chk("t5_no_rsp", rsp_cnt, 2);
    req_valid = 2'b01;
    #1;
    chk("t5_stuck", {30'd0, req_ready}, 32'd0);
    req_valid = '0;
`endif
    mute = 1'b0;

    // Reset mid-WAIT drops the op; requester 0 wins first afterwards
    mdly = 20;
    req_a = {8'd0, 8'd1};
    req_b = {8'd0, 8'd1};
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    repeat (3) tick();
    rst = 1'b1;
    exp_q.delete();
    op_q.delete();
    gl.delete();
    nr = rsp_cnt;
    tick();
    rst = 1'b0;
    chk_idle_zero("t1");
    chk("t1_no_rsp", rsp_cnt, nr);

    // Contention: both held, alternating grants, next winner right after each response
    mdly = 2;
    req_a = {8'd250, 8'd11};
    req_b = {8'd250, 8'd13};
    req_valid = 2'b11;
    #1;
    chk("t1_first_grant", {30'd0, req_ready}, 32'd1);
    nr = 0;
    for (int k = 0; k < 200 && nr < 4; k++) begin
      tick();
      if (rsp_valid != '0) begin
        o = rsp_valid;
        nr++;
        tick();
        chk("t6_next_ready", {30'd0, req_ready}, (o == 2'b01) ? 32'd2 : 32'd1);
      end
    end
    req_valid = '0;
    chk("t3_rsp_count", nr, 4);
    chk("t3_grants", gl.size(), 4);
    for (int k = 0; k < 4 && k < gl.size(); k++) chk("t3_order", gl[k], k % 2);

    repeat (5) tick();
    chk("sb_empty", exp_q.size(), 0);
    chk("op_empty", op_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
